button_conditioner: RTL and testbench

- Front-end stage that feeds the 4-bit up/down display counter.
- Takes three raw, asynchronous push-button inputs and synchronizes and debounces each one.
- Converts every confirmed press into a single-cycle add/delete/load pulse, with optional auto-repeat on add/delete.
- Output pulses are mutually exclusive, so the counter never sees simultaneous commands.

---
 rtl/button_conditioner.sv | 190 +++++++++++++++++++
 tb/tb_button_conditioner.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - sync, debounce, auto-repeat and arbitrate three push buttons
// into mutually exclusive one-cycle add/delete/load commands.

module button_conditioner_channel #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit CAN_REPEAT      = 1'b1,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic ack,
    output logic pending,
    output logic level
);
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic             sync1;
    logic             s;
    state_t           state;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_inc;
    logic             repeating;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    assign timer_inc = (timer == CNT_MAX) ? timer : timer + 1'b1;

    // A new event set in the same cycle as an ack wins, so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            timer     <= '0;
            repeating <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (ack) begin
                pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (s) begin
                        state <= PRESS_WAIT;
                        timer <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (timer == DEB_LAST) begin
                        state     <= HELD;
                        timer     <= '0;
                        repeating <= 1'b0;
                        pending   <= 1'b1;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                HELD: begin
                    if (!s) begin
                        state <= RELEASE_WAIT;
                        timer <= '0;
                    end else if (CAN_REPEAT) begin
                        // First repeat waits the long delay, later ones the short period.
                        if ((!repeating && timer == DLY_LAST) ||
                            (repeating && timer == PER_LAST)) begin
                            pending   <= 1'b1;
                            repeating <= 1'b1;
                            timer     <= '0;
                        end else begin
                            timer <= timer_inc;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state     <= HELD;
                        timer     <= '0;
                        repeating <= 1'b0;
                    end else if (timer == DEB_LAST) begin
                        state <= IDLE;
                        timer <= '0;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign level = (state == HELD) || (state == RELEASE_WAIT);

endmodule

module button_conditioner #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_add_raw,
    input  logic       btn_delete_raw,
    input  logic       btn_load_raw,
    output logic       add,
    output logic       delete,
    output logic       load,
    output logic [2:0] btn_level
);
    localparam bit REP = (REPEAT_EN != 0);

    logic [2:0] pend;
    logic [2:0] grant;

    button_conditioner_channel #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CAN_REPEAT(REP),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_add (
        .clk(clk), .reset(reset), .raw(btn_add_raw), .ack(grant[0]),
        .pending(pend[0]), .level(btn_level[0])
    );

    button_conditioner_channel #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CAN_REPEAT(REP),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_delete (
        .clk(clk), .reset(reset), .raw(btn_delete_raw), .ack(grant[1]),
        .pending(pend[1]), .level(btn_level[1])
    );

    // Load clears the counter, so holding it must never re-issue the command.
    button_conditioner_channel #(
        .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CAN_REPEAT(1'b0),
        .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_load (
        .clk(clk), .reset(reset), .raw(btn_load_raw), .ack(grant[2]),
        .pending(pend[2]), .level(btn_level[2])
    );

    always_comb begin
        grant = 3'b000;
        if (pend[2]) begin
            grant = 3'b100;
        end else if (pend[1]) begin
            grant = 3'b010;
        end else if (pend[0]) begin
            grant = 3'b001;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            add    <= 1'b0;
            delete <= 1'b0;
            load   <= 1'b0;
        end else begin
            add    <= grant[0];
            delete <= grant[1];
            load   <= grant[2];
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - randomized and directed bench for button_conditioner
// against a run-length reference model.
`timescale 1ns/1ps

module tb_button_conditioner;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int MAXN = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_add_raw = 1'b0, btn_delete_raw = 1'b0, btn_load_raw = 1'b0;
    logic add1, delete1, load1, add2, delete2, load2;
    logic [2:0] level1, level2;

    int n_checks = 0;
    int n_fail = 0;

    logic [2:0] rv  [MAXN];
    logic [2:0] o1  [MAXN];
    logic [2:0] l1  [MAXN];
    logic [2:0] o2  [MAXN];
    logic [2:0] l2  [MAXN];
    logic [2:0] eo1 [MAXN];
    logic [2:0] el1 [MAXN];
    logic [2:0] eo2 [MAXN];
    logic [2:0] el2 [MAXN];

    always #5 clk = ~clk;

    button_conditioner #(
        .CNT_W(8), .DEBOUNCE_CYCLES(D), .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_rep (
        .clk(clk), .reset(reset), .btn_add_raw(btn_add_raw), .btn_delete_raw(btn_delete_raw),
        .btn_load_raw(btn_load_raw), .add(add1), .delete(delete1), .load(load1), .btn_level(level1)
    );

    button_conditioner #(
        .CNT_W(8), .DEBOUNCE_CYCLES(D), .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_norep (
        .clk(clk), .reset(reset), .btn_add_raw(btn_add_raw), .btn_delete_raw(btn_delete_raw),
        .btn_load_raw(btn_load_raw), .add(add2), .delete(delete2), .load(load2), .btn_level(level2)
    );

    task automatic clear_stim();
        for (int n = 0; n < MAXN; n++) rv[n] = 3'b000;
    endtask

    task automatic do_reset(input logic [2:0] raw_during);
        @(negedge clk);
        reset = 1'b1;
        {btn_load_raw, btn_delete_raw, btn_add_raw} = raw_during;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Entered at a negedge; rv[n] is what edge n samples, outputs are recorded after edge n.
    task automatic run_seg(input int n_cyc);
        for (int n = 0; n < n_cyc; n++) begin
            {btn_load_raw, btn_delete_raw, btn_add_raw} = rv[n];
            @(posedge clk);
            @(negedge clk);
            o1[n] = {load1, delete1, add1};
            l1[n] = level1;
            o2[n] = {load2, delete2, add2};
            l2[n] = level2;
        end
    endtask

    // A debounced level flips once D+1 consecutive qualifier samples disagree with it;
    // a press is an event, and an unbroken high run inside a press repeats after RD then every RP.
    task automatic build_expected(input int n_cyc);
        logic [2:0] x [MAXN];
        logic [2:0] evt [MAXN];
        logic [2:0] lvh [MAXN];
        logic [2:0] pend;
        logic [2:0] gnt;
        bit lvl;
        bit flip;
        int t0;
        for (int n = 0; n < n_cyc; n++) x[n] = (n >= 2) ? rv[n-2] : 3'b000;
        for (int rep = 0; rep < 2; rep++) begin
            for (int b = 0; b < 3; b++) begin
                lvl = 1'b0;
                t0 = -1;
                for (int n = 0; n < n_cyc; n++) begin
                    evt[n][b] = 1'b0;
                    flip = (n >= D);
                    for (int k = 0; k <= D; k++)
                        if (n - k >= 0 && x[n-k][b] == lvl) flip = 1'b0;
                    if (flip) begin
                        lvl = !lvl;
                        if (lvl) begin
                            evt[n][b] = 1'b1;
                            t0 = n;
                        end
                    end else if (lvl && x[n][b]) begin
                        if (!x[n-1][b]) t0 = n;
                        else if (rep == 1 && b != 2 && n - t0 >= RD && (n - t0 - RD) % RP == 0)
                            evt[n][b] = 1'b1;
                    end
                    lvh[n][b] = lvl;
                end
            end
            pend = 3'b000;
            for (int n = 0; n < n_cyc; n++) begin
                gnt = pend[2] ? 3'b100 : pend[1] ? 3'b010 : pend[0] ? 3'b001 : 3'b000;
                pend = (pend & ~gnt) | evt[n];
                if (rep == 1) begin
                    eo1[n] = gnt;
                    el1[n] = lvh[n];
                end else begin
                    eo2[n] = gnt;
                    el2[n] = lvh[n];
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({o1[0], level1, add2, delete2, load2, level2} !== 0 || {add1, delete1, load1} !== 0) begin
            n_fail++;
            $display("FAIL reset_state: rep out/lvl %b/%b norep out/lvl %b/%b, required all 0",
                     {load1, delete1, add1}, level1, {load2, delete2, add2}, level2);
        end
        // Pending flags and a live pulse must vanish on async reset.
        clear_stim();
        for (int n = 0; n < 8; n++) rv[n] = 3'b111;
        do_reset(3'b000);
        run_seg(8);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({load1, delete1, add1, load2, delete2, add2} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_async_clear: outputs %b%b, required 000000",
                     {load1, delete1, add1}, {load2, delete2, add2});
        end
        clear_stim();
        do_reset(3'b000);
        run_seg(30);
        build_expected(30);
        for (int n = 0; n < 30; n++) begin
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL reset_discard cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
    endtask

    task automatic test_clean_press();
        int cnt1, cnt2;
        clear_stim();
        for (int n = 0; n < 50; n++) rv[n] = 3'b001;
        do_reset(3'b000);
        run_seg(70);
        build_expected(70);
        cnt1 = 0;
        cnt2 = 0;
        for (int n = 0; n < 70; n++) begin
            cnt1 += int'(o1[n][0]);
            cnt2 += int'(o2[n][0]);
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL clean_press cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (o1[6] !== 3'b000 || o1[7] !== 3'b001 || o1[8] !== 3'b000) begin
            n_fail++;
            $display("FAIL clean_latency: cycles 6..8 %b %b %b, required 000 001 000", o1[6], o1[7], o1[8]);
        end
        n_checks++;
        if (o1[27] !== 3'b001 || o1[35] !== 3'b001 || o1[43] !== 3'b001 || o1[51] !== 3'b001) begin
            n_fail++;
            $display("FAIL clean_repeat: cycles 27/35/43/51 %b %b %b %b, required 001 each",
                     o1[27], o1[35], o1[43], o1[51]);
        end
        n_checks++;
        if (cnt1 != 5 || cnt2 != 1) begin
            n_fail++;
            $display("FAIL clean_count: add pulses rep %0d norep %0d, required 5 and 1", cnt1, cnt2);
        end
    endtask

    task automatic test_bounce();
        int cnt, lv;
        clear_stim();
        for (int n = 0; n < 40; n++) rv[n] = ((n % 4) != 3) ? 3'b010 : 3'b000;
        do_reset(3'b000);
        run_seg(60);
        build_expected(60);
        cnt = 0;
        lv = 0;
        for (int n = 0; n < 60; n++) begin
            cnt += int'(o1[n][1]) + int'(o2[n][1]);
            lv += int'(l1[n][1]) + int'(l2[n][1]);
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL bounce cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (cnt != 0 || lv != 0) begin
            n_fail++;
            $display("FAIL bounce_quiet: delete pulses %0d level-high cycles %0d, required 0 and 0", cnt, lv);
        end
    endtask

    task automatic test_simultaneous();
        clear_stim();
        for (int n = 0; n < 10; n++) rv[n] = 3'b111;
        do_reset(3'b000);
        run_seg(30);
        build_expected(30);
        for (int n = 0; n < 30; n++) begin
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL simultaneous cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (o1[7] !== 3'b100 || o1[8] !== 3'b010 || o1[9] !== 3'b001 || o1[10] !== 3'b000) begin
            n_fail++;
            $display("FAIL simultaneous_order: cycles 7..10 %b %b %b %b, required 100 010 001 000",
                     o1[7], o1[8], o1[9], o1[10]);
        end
    endtask

    task automatic test_release_bounce();
        int cnt;
        clear_stim();
        for (int n = 0; n < 10; n++) rv[n] = 3'b100;
        rv[11] = 3'b100;
        rv[13] = 3'b100;
        do_reset(3'b000);
        run_seg(35);
        build_expected(35);
        cnt = 0;
        for (int n = 0; n < 35; n++) begin
            cnt += int'(o1[n][2]);
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL release_bounce cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (cnt != 1 || l1[19][2] !== 1'b1 || l1[20][2] !== 1'b0) begin
            n_fail++;
            $display("FAIL release_level: load pulses %0d level@19 %b level@20 %b, required 1 1 0",
                     cnt, l1[19][2], l1[20][2]);
        end
    endtask

    task automatic test_reset_mid();
        int cnt;
        clear_stim();
        for (int n = 0; n < 5; n++) rv[n] = 3'b001;
        do_reset(3'b000);
        run_seg(5);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({load1, delete1, add1, level1, load2, delete2, add2, level2} !== 12'b0) begin
                n_fail++;
                $display("FAIL reset_mid_hold %0d: rep %b/%b norep %b/%b, required 0",
                         c, {load1, delete1, add1}, level1, {load2, delete2, add2}, level2);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        clear_stim();
        for (int n = 0; n < 20; n++) rv[n] = 3'b001;
        run_seg(30);
        build_expected(30);
        cnt = 0;
        for (int n = 0; n < 30; n++) begin
            cnt += int'(o1[n][0]);
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (cnt != 1 || o1[D+3] !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: add pulses %0d cycle %0d out %b, required 1 and 001",
                     cnt, D + 3, o1[D+3]);
        end
    endtask

    task automatic test_no_repeat();
        int cnt1, cnt2;
        clear_stim();
        for (int n = 0; n < 60; n++) rv[n] = 3'b010;
        do_reset(3'b000);
        run_seg(75);
        build_expected(75);
        cnt1 = 0;
        cnt2 = 0;
        for (int n = 0; n < 75; n++) begin
            cnt1 += int'(o1[n][1]);
            cnt2 += int'(o2[n][1]);
            n_checks++;
            if ({o1[n], l1[n], o2[n], l2[n]} !== {eo1[n], el1[n], eo2[n], el2[n]}) begin
                n_fail++;
                $display("FAIL no_repeat cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                         n, o1[n], l1[n], o2[n], l2[n], eo1[n], el1[n], eo2[n], el2[n]);
            end
        end
        n_checks++;
        if (cnt2 != 1 || cnt1 != 6) begin
            n_fail++;
            $display("FAIL no_repeat_count: delete pulses norep %0d rep %0d, required 1 and 6", cnt2, cnt1);
        end
    endtask

    task automatic test_random();
        int n, len;
        bit v;
        for (int it = 0; it < 4; it++) begin
            clear_stim();
            for (int b = 0; b < 3; b++) begin
                n = 0;
                v = 1'b0;
                while (n < 300) begin
                    len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 6));
                    for (int k = 0; k < len && n < 300; k++) begin
                        rv[n][b] = v;
                        n++;
                    end
                    v = !v;
                end
            end
            do_reset(3'b000);
            run_seg(300);
            build_expected(300);
            for (int c = 0; c < 300; c++) begin
                n_checks++;
                if ({o1[c], l1[c], o2[c], l2[c]} !== {eo1[c], el1[c], eo2[c], el2[c]}) begin
                    n_fail++;
                    $display("FAIL random it %0d cycle %0d: got %b/%b %b/%b required %b/%b %b/%b",
                             it, c, o1[c], l1[c], o2[c], l2[c], eo1[c], el1[c], eo2[c], el2[c]);
                end
            end
        end
    endtask

    initial begin
        o1[0] = 3'b000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_release_bounce();
        test_reset_mid();
        test_no_repeat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
